// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and defaults for the parametrised register file and its scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundles the read, write, reserve and status signals of the register file.
// Latency: n/a (wiring only).
// Backpressure: none; the pipeline stalls on rs_busy and waits for ready.
interface regfile_scoreboard_if import regfile_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREG);

  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  ready;

  // Pipeline side: drives addresses and strobes, observes data and status.
  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rs_busy, ready
  );

  // Register file side.
  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rs_busy, ready
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, zero-register override, write bypass, busy lookup.
// Latency: zero cycles (purely combinational).
// Backpressure: none; outputs are forced to zero while the file is clearing.
module regfile_read_port import regfile_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                      run,
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy_vec,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  input  logic [AW-1:0]             addr,
  output logic [XLEN-1:0]           data,
  output logic                      busy
);

  logic is_zero;
  logic wr_hit;
  logic rsv_hit;

  // Select data and busy, then apply bypass, zero-register and clearing overrides in priority order.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (addr == '0);
    wr_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr) && !is_zero;
    rsv_hit = rsv_en && (rsv_addr == addr);
    data    = regs[addr];
    busy    = busy_vec[addr];
    if (wr_hit) begin
      data = wr_data;
      // A same-cycle reservation of this register keeps the stall in place.
      if (!rsv_hit) busy = 1'b0;
    end
    if (is_zero) begin
      data = '0;
      busy = 1'b0;
    end
    if (!run) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard and a one-entry-per-cycle clear sequencer.
// Latency: reads zero cycles, writes and reservations take effect at the next edge; ready NREG cycles after reset.
// Backpressure: none; writes and reservations are ignored until ready, consumers stall on rs_busy.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input logic                clk,
  input logic                reset,
  regfile_scoreboard_if.slave bus
);

  state_t                    state_q;
  state_t                    state_d;
  logic [AW-1:0]             clr_idx;
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           busy_d;
  logic                      run;
  logic                      last_clr;
  logic                      wr_ok;

  assign run       = (state_q == RUN);
  assign bus.ready = run;
  assign last_clr  = (clr_idx == AW'(NREG - 1));
  assign wr_ok     = run && bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (last_clr) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Clear index walks the array once after every reset.
  always_ff @(posedge clk) begin
    if (reset)     clr_idx <= '0;
    else if (!run) clr_idx <= clr_idx + 1'b1;
  end

  // Array update: zero one entry per cycle while clearing, otherwise accept writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run)       regs[clr_idx]     <= '0;
      else if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard next value: reservation beats a same-cycle write to the same register.
  always_comb begin
    busy_d = busy;
    if (run) begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.rsv_en && (bus.rsv_addr == AW'(i)))     busy_d[i] = 1'b1;
        else if (bus.wr_en && (bus.wr_addr == AW'(i)))  busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_d;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rp (
      .run      (run),
      .regs     (regs),
      .busy_vec (busy),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rsv_en   (bus.rsv_en),
      .rsv_addr (bus.rsv_addr),
      .addr     (bus.rs_addr[k*AW +: AW]),
      .data     (bus.rd_data[k*XLEN +: XLEN]),
      .busy     (bus.rs_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: default file, a no-bypass twin fed the same stimulus, and a 32-bit/16-entry/3-port variant.
// Latency: vectors are checked combinationally on the falling edge before the committing rising edge.
// Backpressure: n/a.
module tb_regfile_scoreboard;

  logic clk;
  logic reset;
  logic rst2;

  regfile_scoreboard_if #(.XLEN(64), .NREG(32), .NREAD(2)) b0 ();
  regfile_scoreboard_if #(.XLEN(64), .NREG(32), .NREAD(2)) b1 ();
  regfile_scoreboard_if #(.XLEN(32), .NREG(16), .NREAD(3)) b2 ();

  regfile_scoreboard #(.XLEN(64), .NREG(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .bus(b0.slave));
  regfile_scoreboard #(.XLEN(64), .NREG(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .bus(b1.slave));
  regfile_scoreboard #(.XLEN(32), .NREG(16), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) u_small (
    .clk(clk), .reset(rst2), .bus(b2.slave));

  assign b1.rs_addr  = b0.rs_addr;
  assign b1.wr_en    = b0.wr_en;
  assign b1.wr_addr  = b0.wr_addr;
  assign b1.wr_data  = b0.wr_data;
  assign b1.rsv_en   = b0.rsv_en;
  assign b1.rsv_addr = b0.rsv_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        eb0;
    logic        eb1;
    logic [63:0] n0;
    logic [63:0] n1;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];
  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input bit we, input int wa, input logic [63:0] wd,
                              input bit re, input int ra, input int r0, input int r1,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input bit eb0, input bit eb1,
                              input logic [63:0] n0, input logic [63:0] n1);
    vec_t t;
    t.wr_en = we;  t.wr_addr = 5'(wa);  t.wr_data = wd;
    t.rsv_en = re; t.rsv_addr = 5'(ra);
    t.rs0 = 5'(r0); t.rs1 = 5'(r1);
    t.d0 = d0; t.d1 = d1; t.eb0 = eb0; t.eb1 = eb1; t.n0 = n0; t.n1 = n1;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count rising edges until ready; also count clearing cycles that show nonzero data or busy.
  task automatic count_ready(input bit use2, output int n, output int bad);
    logic rdy;
    n = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      rdy = use2 ? b2.ready : b0.ready;
      if (!rdy && !use2 && ((b0.rd_data != '0) || (b0.rs_busy != '0))) bad++;
    end while (!rdy && n < 100);
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    b0.wr_en    = t.wr_en;
    b0.wr_addr  = t.wr_addr;
    b0.wr_data  = t.wr_data;
    b0.rsv_en   = t.rsv_en;
    b0.rsv_addr = t.rsv_addr;
    b0.rs_addr  = {t.rs1, t.rs0};
    exp_q.push_back(t);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("v%0d rd0", idx),      b0.rd_data[63:0],   e.d0);
    check($sformatf("v%0d rd1", idx),      b0.rd_data[127:64], e.d1);
    check($sformatf("v%0d busy0", idx),    64'(b0.rs_busy[0]), 64'(e.eb0));
    check($sformatf("v%0d busy1", idx),    64'(b0.rs_busy[1]), 64'(e.eb1));
    check($sformatf("v%0d nobyp rd0", idx), b1.rd_data[63:0],   e.n0);
    check($sformatf("v%0d nobyp rd1", idx), b1.rd_data[127:64], e.n1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0;
    b0.rsv_en = 1'b0; b0.rsv_addr = '0; b0.rs_addr = '0;
  endtask

  initial begin
    int n;
    int bad;
    logic [63:0] dv;

    dv = 64'hDEAD_BEEF_0000_0001;
    tbl[0]  = mk(1, 5, dv,     0, 0, 5, 0, dv, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,      0, 0, 5, 0, dv, 0, 0, 0, dv, 0);
    tbl[2]  = mk(1, 0, 'h1234, 0, 0, 0, 5, 0, dv, 0, 0, 0, dv);
    tbl[3]  = mk(0, 0, 0,      0, 0, 0, 5, 0, dv, 0, 0, 0, dv);
    tbl[4]  = mk(1, 7, 'hA5A5, 0, 0, 5, 7, dv, 'hA5A5, 0, 0, dv, 0);
    tbl[5]  = mk(0, 0, 0,      0, 0, 5, 7, dv, 'hA5A5, 0, 0, dv, 'hA5A5);
    tbl[6]  = mk(0, 0, 0,      1, 9, 9, 7, 0, 'hA5A5, 0, 0, 0, 'hA5A5);
    tbl[7]  = mk(0, 0, 0,      0, 0, 9, 9, 0, 0, 1, 1, 0, 0);
    tbl[8]  = mk(1, 9, 'h99,   0, 0, 9, 9, 'h99, 'h99, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,      0, 0, 9, 7, 'h99, 'hA5A5, 0, 0, 'h99, 'hA5A5);
    tbl[10] = mk(1, 9, 'hAA,   1, 9, 9, 9, 'hAA, 'hAA, 0, 0, 'h99, 'h99);
    tbl[11] = mk(0, 0, 0,      0, 0, 9, 0, 'hAA, 0, 1, 0, 'hAA, 0);
    tbl[12] = mk(0, 0, 0,      1, 0, 0, 9, 0, 'hAA, 0, 1, 0, 'hAA);
    tbl[13] = mk(0, 0, 0,      0, 0, 0, 9, 0, 'hAA, 0, 1, 0, 'hAA);
    tbl[14] = mk(0, 0, 0,      1, 9, 9, 9, 'hAA, 'hAA, 1, 1, 'hAA, 'hAA);
    tbl[15] = mk(1, 9, 'hBB,   0, 0, 9, 3, 'hBB, 0, 0, 0, 'hAA, 0);
    tbl[16] = mk(0, 0, 0,      0, 0, 9, 5, 'hBB, dv, 0, 0, 'hBB, dv);
    tbl[17] = mk(1, 5, 'h5555, 0, 0, 9, 5, 'hBB, 'h5555, 0, 0, 'hBB, dv);
    tbl[18] = mk(0, 0, 0,      0, 0, 5, 9, 'h5555, 'hBB, 0, 0, 'h5555, 'hBB);
    tbl[19] = mk(0, 0, 0,      1, 9, 3, 9, 0, 'hBB, 0, 0, 0, 'hBB);
    tbl[20] = mk(1, 3, 'h55,   0, 0, 3, 9, 'h55, 'hBB, 0, 1, 0, 'hBB);
    tbl[21] = mk(0, 0, 0,      0, 0, 3, 9, 'h55, 'hBB, 0, 1, 'h55, 'hBB);

    reset = 1'b1;
    rst2  = 1'b1;
    idle0();
    b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0;
    b2.rsv_en = 1'b0; b2.rsv_addr = '0; b2.rs_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(b0.ready), 64'd0);
    check("reset busy", 64'(b0.rs_busy), 64'd0);

    // Clear sequence after reset release.
    reset = 1'b0;
    count_ready(1'b0, n, bad);
    check("ready latency", 64'(n), 64'd32);
    check("clear outputs zero", 64'(bad), 64'd0);
    check("nobyp ready", 64'(b1.ready), 64'd1);

    // Every register reads zero and not busy once ready.
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      b0.rs_addr = {5'(31 - a), 5'(a)};
      #1;
      if ((b0.rd_data != '0) || (b0.rs_busy != '0)) bad++;
    end
    check("all regs zero", 64'(bad), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) apply(tbl[i], i);
    idle0();

    // Reset mid-RUN, then again mid-CLEAR at index 10 with writes/reserves held active.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    b0.wr_en = 1'b1; b0.wr_addr = 5'd3; b0.wr_data = 64'h77;
    b0.rsv_en = 1'b1; b0.rsv_addr = 5'd4;
    b0.rs_addr = {5'd4, 5'd3};
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_ready(1'b0, n, bad);
    check("re-clear latency", 64'(n), 64'd32);
    check("re-clear outputs zero", 64'(bad), 64'd0);
    idle0();
    b0.rs_addr = {5'd4, 5'd3};
    #1;
    check("x3 cleared", b0.rd_data[63:0], 64'd0);
    check("x4 not busy", 64'(b0.rs_busy[1]), 64'd0);
    b0.rs_addr = {5'd9, 5'd5};
    #1;
    check("x9 busy cleared", 64'(b0.rs_busy[1]), 64'd0);
    check("x5 cleared", b0.rd_data[63:0], 64'd0);
    @(posedge clk);
    #1;

    // Small variant: 16 entries, three read ports.
    rst2 = 1'b0;
    count_ready(1'b1, n, bad);
    check("small ready latency", 64'(n), 64'd16);
    b2.wr_en = 1'b1;
    b2.wr_addr = 4'd1;  b2.wr_data = 32'd1;  @(posedge clk); #1;
    b2.wr_addr = 4'd2;  b2.wr_data = 32'd2;  @(posedge clk); #1;
    b2.wr_addr = 4'd15; b2.wr_data = 32'd15; @(posedge clk); #1;
    b2.wr_en = 1'b0;
    b2.rs_addr = {4'd15, 4'd2, 4'd1};
    #2;
    check("small port0", 64'(b2.rd_data[31:0]),  64'd1);
    check("small port1", 64'(b2.rd_data[63:32]), 64'd2);
    check("small port2", 64'(b2.rd_data[95:64]), 64'd15);
    check("small busy", 64'(b2.rs_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
